reg_write_scheduler: RTL and testbench

Write-back scheduler that shares the clocked register file's single write port between the ALU write-back path and the load (memory) write-back path. Accepted requests enter a shared in-order queue and drain one per cycle onto the register-file write port (`write_en`/`write_addr`/`reg_data`). It also publishes a per-register pending-write mask for the hazard unit and rejects any write aimed at the PC register.

---
 rtl/reg_pkg.sv | 22 ++
 rtl/reg_write_scheduler_queue.sv | 79 +++++++
 rtl/reg_write_scheduler.sv | 120 ++++++++++++
 tb/tb_reg_write_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// -----------------------------------------------------------------------------
// reg_pkg
// Register-file constants and the write-back request type. The register
// file and the write-back scheduler both import this package, so the
// register numbering and the request layout are defined in one place.
// -----------------------------------------------------------------------------
package reg_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;
  localparam int REG_WORD   = 32;

  localparam logic [REG_ADDR_W-1:0] SP_REG_NUM = 4'd13;
  localparam logic [REG_ADDR_W-1:0] PC_REG_NUM = 4'd15;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_WORD-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/reg_write_scheduler_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
// In-order FIFO of write-back requests with two ordered push ports and one
// pop port. When both pushes fire in the same cycle, push_a takes the older
// slot. The caller must guarantee room for every push (count <= DEPTH-2
// whenever pushes are offered).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_a, req_a       first (older) push
//   push_b, req_b       second (younger) push
//   pop                 remove the head entry (only when count != 0)
//   head                oldest entry
//   count               occupied entries, 0..DEPTH
//   entry_valid/addr    per-slot occupancy and destination register
// -----------------------------------------------------------------------------
module wb_queue
  import reg_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push_a,
  input  wb_req_t                          req_a,
  input  logic                             push_b,
  input  wb_req_t                          req_b,
  input  logic                             pop,
  output wb_req_t                          head,
  output logic [PW:0]                      count,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_b;
  logic [1:0]    num_push;
  wb_req_t       slots [DEPTH];

  assign num_push = {1'b0, push_a} + {1'b0, push_b};
  // push_b lands behind push_a when both fire together.
  assign wr_ptr_b = push_a ? wr_ptr + PW'(1) : wr_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(num_push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + (PW+1)'(num_push) - (PW+1)'(pop);
    end
  end

  // NOTE: the payload storage has no reset; a slot's contents only matter
  // while count/pointers mark it occupied, and those are reset.
  always_ff @(posedge clk) begin
    if (push_a) slots[wr_ptr]   <= req_a;
    if (push_b) slots[wr_ptr_b] <= req_b;
  end

  assign head = slots[rd_ptr];

  // A slot is occupied when its distance from the read pointer is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] offset;
      offset         = PW'(i) - rd_ptr;
      entry_valid[i] = {1'b0, offset} < count;
      entry_addr[i]  = slots[i].addr;
    end
  end

endmodule

// File: rtl/reg_write_scheduler.sv
// -----------------------------------------------------------------------------
// reg_write_scheduler
// Shares the register file's single write port between the load and ALU
// write-back paths. Accepted requests go through one in-order queue and
// drain one per cycle into a registered output stage. Writes aimed at the
// PC are accepted but dropped, and flagged with a one-cycle error pulse.
// The request width follows reg_pkg (WORD/ADDR_WIDTH must match it).
//
// Ports:
//   clk_i, rst_n_i                         clock, async active-low reset
//   mem_valid_i/addr_i/data_i, mem_ready_o load write-back request
//   alu_valid_i/addr_i/data_i, alu_ready_o ALU write-back request
//   write_en_o/write_addr_o/reg_data_o     registered register-file write
//   busy_mask_o                            registers with a write in flight
//   pc_write_err_o                         accepted request targeted the PC
// -----------------------------------------------------------------------------
module reg_write_scheduler
  import reg_pkg::*;
#(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     mem_valid_i,
  input  logic [ADDR_WIDTH-1:0]    mem_addr_i,
  input  logic [WORD-1:0]          mem_data_i,
  output logic                     mem_ready_o,
  input  logic                     alu_valid_i,
  input  logic [ADDR_WIDTH-1:0]    alu_addr_i,
  input  logic [WORD-1:0]          alu_data_i,
  output logic                     alu_ready_o,
  output logic                     write_en_o,
  output logic [ADDR_WIDTH-1:0]    write_addr_o,
  output logic [WORD-1:0]          reg_data_o,
  output logic [2**ADDR_WIDTH-1:0] busy_mask_o,
  output logic                     pc_write_err_o
);

  localparam int PW = $clog2(DEPTH);

  logic                             ready;
  logic                             mem_fire;
  logic                             alu_fire;
  logic                             mem_is_pc;
  logic                             alu_is_pc;
  logic                             push_a;
  logic                             push_b;
  logic                             pop;
  wb_req_t                          req_a;
  wb_req_t                          req_b;
  wb_req_t                          head;
  logic [PW:0]                      count;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;

  // Ready depends only on occupancy, leaving room for two pushes.
  assign ready       = count <= (PW+1)'(DEPTH - 2);
  assign mem_ready_o = ready;
  assign alu_ready_o = ready;

  assign mem_fire  = mem_valid_i && ready;
  assign alu_fire  = alu_valid_i && ready;
  assign mem_is_pc = mem_addr_i == PC_REG_NUM;
  assign alu_is_pc = alu_addr_i == PC_REG_NUM;

  // PC writes complete the handshake but never enter the queue.
  assign push_a = mem_fire && !mem_is_pc;
  assign push_b = alu_fire && !alu_is_pc;
  assign pop    = count != '0;

  assign req_a = '{addr: mem_addr_i, data: mem_data_i};
  assign req_b = '{addr: alu_addr_i, data: alu_data_i};

  // The load path feeds the older slot: it belongs to the older instruction.
  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk_i),
    .rst_n       (rst_n_i),
    .push_a      (push_a),
    .req_a       (req_a),
    .push_b      (push_b),
    .req_b       (req_b),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // Output stage: address/data hold their last value when nothing drains.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      write_en_o     <= 1'b0;
      write_addr_o   <= '0;
      reg_data_o     <= '0;
      pc_write_err_o <= 1'b0;
    end else begin
      write_en_o     <= pop;
      pc_write_err_o <= (mem_fire && mem_is_pc) || (alu_fire && alu_is_pc);
      if (pop) begin
        write_addr_o <= head.addr;
        reg_data_o   <= head.data;
      end
    end
  end

  // NOTE: the mask gets a full default before the loop so no bit is left
  // unassigned on any path, which would otherwise infer a latch.
  always_comb begin
    busy_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) busy_mask_o[entry_addr[i]] = 1'b1;
    end
    if (write_en_o) busy_mask_o[write_addr_o] = 1'b1;
  end

endmodule

// File: tb/tb_reg_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_reg_write_scheduler
// Drives directed and random write-back traffic and compares the scheduler
// against a queue-based reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_reg_write_scheduler;

  localparam int WORD  = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int NREG  = 16;
  localparam logic [AW-1:0] PC = 4'd15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mem_valid = 1'b0;
  logic [AW-1:0]   mem_addr = '0;
  logic [WORD-1:0] mem_data = '0;
  logic            mem_ready;
  logic            alu_valid = 1'b0;
  logic [AW-1:0]   alu_addr = '0;
  logic [WORD-1:0] alu_data = '0;
  logic            alu_ready;
  logic            write_en;
  logic [AW-1:0]   write_addr;
  logic [WORD-1:0] reg_data;
  logic [NREG-1:0] busy_mask;
  logic            pc_write_err;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: pending writes in acceptance order plus the visible
  // register-file write of the current cycle.
  typedef struct {
    logic [AW-1:0]   addr;
    logic [WORD-1:0] data;
  } wr_t;

  wr_t             exp_q[$];
  logic            exp_en   = 1'b0;
  logic [AW-1:0]   exp_addr = '0;
  logic [WORD-1:0] exp_data = '0;
  logic            exp_err  = 1'b0;
  int              accepted = 0;

  always #5 clk = ~clk;

  reg_write_scheduler #(
    .WORD       (WORD),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .mem_valid_i    (mem_valid),
    .mem_addr_i     (mem_addr),
    .mem_data_i     (mem_data),
    .mem_ready_o    (mem_ready),
    .alu_valid_i    (alu_valid),
    .alu_addr_i     (alu_addr),
    .alu_data_i     (alu_data),
    .alu_ready_o    (alu_ready),
    .write_en_o     (write_en),
    .write_addr_o   (write_addr),
    .reg_data_o     (reg_data),
    .busy_mask_o    (busy_mask),
    .pc_write_err_o (pc_write_err)
  );

  function automatic logic exp_ready();
    return exp_q.size() <= DEPTH - 2;
  endfunction

  function automatic logic [NREG-1:0] exp_busy();
    logic [NREG-1:0] m;
    m = '0;
    foreach (exp_q[i]) m[exp_q[i].addr] = 1'b1;
    if (exp_en) m[exp_addr] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_en   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_err  = 1'b0;
  endtask

  // One clock cycle: drive both ports from a negedge, advance the model at
  // the posedge, return at the next negedge with valids cleared.
  task automatic step(input logic mv, input logic [AW-1:0] ma, input logic [WORD-1:0] md,
                      input logic av, input logic [AW-1:0] aa, input logic [WORD-1:0] ad);
    logic rdy;
    wr_t  w;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    rdy = exp_ready();
    @(posedge clk);
    exp_err = (mv && rdy && ma == PC) || (av && rdy && aa == PC);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      exp_en = 1'b1; exp_addr = w.addr; exp_data = w.data;
    end else begin
      exp_en = 1'b0;
    end
    if (mv && rdy && ma != PC) begin exp_q.push_back('{ma, md}); accepted++; end
    if (av && rdy && aa != PC) begin exp_q.push_back('{aa, ad}); accepted++; end
    @(negedge clk);
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'h55;
    alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 32'h66;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (write_en !== 1'b0 || busy_mask !== '0 || pc_write_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: en=%b busy=%h err=%b, expected 0/0/0", write_en, busy_mask, pc_write_err);
    end
    tests_run++;
    if (write_addr !== '0 || reg_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_addr_data: addr=%h data=%h, expected 0/0", write_addr, reg_data);
    end
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: mem=%b alu=%b, expected 1/1", mem_ready, alu_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single_write();
    step(1'b0, '0, '0, 1'b1, 4'd3, 32'hDEADBEEF);
    tests_run++;
    if (write_en !== 1'b0 || busy_mask !== 16'h0008) begin
      tests_failed++;
      $display("FAIL single_cycle1: en=%b busy=%h, expected 0/0008", write_en, busy_mask);
    end
    idle();
    tests_run++;
    if (write_en !== 1'b1 || write_addr !== 4'd3 || reg_data !== 32'hDEADBEEF || busy_mask !== 16'h0008) begin
      tests_failed++;
      $display("FAIL single_write: en=%b addr=%h data=%h busy=%h, expected 1/3/deadbeef/0008",
               write_en, write_addr, reg_data, busy_mask);
    end
    idle();
    tests_run++;
    if (write_en !== 1'b0 || busy_mask !== 16'h0000 || write_addr !== 4'd3 || reg_data !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL single_after: en=%b busy=%h addr=%h data=%h, expected 0/0000/3/deadbeef (held)",
               write_en, busy_mask, write_addr, reg_data);
    end
  endtask

  task automatic test_same_cycle_order();
    logic [WORD-1:0] want [2];
    want[0] = 32'h1;
    want[1] = 32'h2;
    step(1'b1, 4'd5, 32'h1, 1'b1, 4'd5, 32'h2);
    tests_run++;
    if (busy_mask !== 16'h0020 || write_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL order_queued: en=%b busy=%h, expected 0/0020", write_en, busy_mask);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      tests_run++;
      if (write_en !== 1'b1 || write_addr !== 4'd5 || reg_data !== want[i] || busy_mask !== 16'h0020) begin
        tests_failed++;
        $display("FAIL order_write%0d: en=%b addr=%h data=%h busy=%h, expected 1/5/%h/0020",
                 i, write_en, write_addr, reg_data, busy_mask, want[i]);
      end
    end
    idle();
    tests_run++;
    if (write_en !== 1'b0 || busy_mask !== 16'h0000) begin
      tests_failed++;
      $display("FAIL order_drained: en=%b busy=%h, expected 0/0000", write_en, busy_mask);
    end
  endtask

  task automatic test_back_to_back();
    int start_acc;
    int writes;
    start_acc = accepted;
    writes = 0;
    for (int c = 0; c < 6; c++) begin
      tests_run++;
      if (mem_ready !== exp_ready() || alu_ready !== exp_ready()) begin
        tests_failed++;
        $display("FAIL b2b_ready c%0d: mem=%b alu=%b expected %b", c, mem_ready, alu_ready, exp_ready());
      end
      step(1'b1, 4'($urandom_range(0, 14)), $urandom, 1'b1, 4'($urandom_range(0, 14)), $urandom);
      if (write_en) writes++;
      tests_run++;
      if (write_en !== exp_en || (exp_en && (write_addr !== exp_addr || reg_data !== exp_data))) begin
        tests_failed++;
        $display("FAIL b2b_write c%0d: en=%b addr=%h data=%h expected %b/%h/%h",
                 c, write_en, write_addr, reg_data, exp_en, exp_addr, exp_data);
      end
    end
    for (int c = 0; c < DEPTH + 2; c++) begin
      idle();
      if (write_en) writes++;
      tests_run++;
      if (write_en !== exp_en || (exp_en && (write_addr !== exp_addr || reg_data !== exp_data))) begin
        tests_failed++;
        $display("FAIL b2b_drain c%0d: en=%b addr=%h data=%h expected %b/%h/%h",
                 c, write_en, write_addr, reg_data, exp_en, exp_addr, exp_data);
      end
    end
    tests_run++;
    if (writes != accepted - start_acc) begin
      tests_failed++;
      $display("FAIL b2b_count: writes=%0d expected %0d", writes, accepted - start_acc);
    end
  endtask

  task automatic test_pc_filter();
    tests_run++;
    if (alu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL pc_ready: alu_ready=%b expected 1", alu_ready);
    end
    step(1'b0, '0, '0, 1'b1, PC, 32'h100);
    tests_run++;
    if (pc_write_err !== 1'b1 || busy_mask !== '0) begin
      tests_failed++;
      $display("FAIL pc_alu_pulse: err=%b busy=%h expected 1/0000", pc_write_err, busy_mask);
    end
    idle();
    tests_run++;
    if (pc_write_err !== 1'b0 || write_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL pc_alu_after: err=%b en=%b expected 0/0", pc_write_err, write_en);
    end
    step(1'b1, PC, 32'h200, 1'b1, PC, 32'h300);
    tests_run++;
    if (pc_write_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL pc_both_pulse: err=%b expected 1", pc_write_err);
    end
    idle();
    tests_run++;
    if (pc_write_err !== 1'b0 || write_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL pc_both_after: err=%b en=%b expected 0/0", pc_write_err, write_en);
    end
    step(1'b1, PC, 32'h400, 1'b1, 4'd7, 32'h77);
    tests_run++;
    if (pc_write_err !== 1'b1 || busy_mask !== 16'h0080) begin
      tests_failed++;
      $display("FAIL pc_mixed: err=%b busy=%h expected 1/0080", pc_write_err, busy_mask);
    end
    idle();
    tests_run++;
    if (write_en !== 1'b1 || write_addr !== 4'd7 || reg_data !== 32'h77 || pc_write_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL pc_mixed_write: en=%b addr=%h data=%h err=%b expected 1/7/77/0",
               write_en, write_addr, reg_data, pc_write_err);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
    step(1'b1, 4'd4, 32'h44, 1'b1, 4'd8, 32'h88);
    tests_run++;
    if (exp_q.size() != 3 || busy_mask !== exp_busy()) begin
      tests_failed++;
      $display("FAIL rmid_fill: busy=%h expected %h (queued %0d)", busy_mask, exp_busy(), exp_q.size());
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (write_en !== 1'b0 || busy_mask !== '0 || mem_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_async: en=%b busy=%h ready=%b expected 0/0000/1", write_en, busy_mask, mem_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_ready: mem=%b alu=%b expected 1/1", mem_ready, alu_ready);
    end
    for (int c = 0; c < 4; c++) begin
      idle();
      tests_run++;
      if (write_en !== 1'b0 || busy_mask !== '0) begin
        tests_failed++;
        $display("FAIL rmid_stale c%0d: en=%b busy=%h expected 0/0000", c, write_en, busy_mask);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      logic mv, av;
      logic [AW-1:0] ma, aa;
      mv = ($urandom_range(0, 9) < 6);
      av = ($urandom_range(0, 9) < 6);
      ma = 4'($urandom_range(0, 15));
      aa = 4'($urandom_range(0, 15));
      tests_run++;
      if (mem_ready !== exp_ready() || alu_ready !== exp_ready()) begin
        tests_failed++;
        $display("FAIL rnd_ready c%0d: mem=%b alu=%b expected %b", c, mem_ready, alu_ready, exp_ready());
      end
      step(mv, ma, $urandom, av, aa, $urandom);
      tests_run++;
      if (write_en !== exp_en || write_addr !== exp_addr || reg_data !== exp_data) begin
        tests_failed++;
        $display("FAIL rnd_write c%0d: en=%b addr=%h data=%h expected %b/%h/%h",
                 c, write_en, write_addr, reg_data, exp_en, exp_addr, exp_data);
      end
      tests_run++;
      if (busy_mask !== exp_busy() || pc_write_err !== exp_err) begin
        tests_failed++;
        $display("FAIL rnd_busy c%0d: busy=%h err=%b expected %h/%b",
                 c, busy_mask, pc_write_err, exp_busy(), exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_same_cycle_order();
    test_back_to_back();
    test_pc_filter();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
